// File: rtl/binary_mul_seq_booth_if.sv
// binary_mul_seq_booth_if: handshake and data bundle for the sequential Booth multiplier.
//   in_valid/in_ready     operand handshake (a, b, signed_mode qualified by in_valid)
//   out_valid/out_ready   product handshake (p qualified by out_valid)
//   busy                  multiplier is in RUN or DONE
//   master: producer/consumer side; slave: multiplier side.
interface binary_mul_seq_booth_if #(
    parameter int WIDTH = 9
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/binary_mul_seq_booth.sv
// binary_mul_seq_booth: iterative radix-2 Booth multiplier, WIDTH+1 steps per product.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of binary_mul_seq_booth_if: operands a/b/signed_mode in via
//        in_valid/in_ready, 2*WIDTH-bit product p out via out_valid/out_ready, busy status.
module binary_mul_seq_booth #(
    parameter int WIDTH = 9
) (
    input logic                  clk,
    input logic                  rst,
    binary_mul_seq_booth_if.slave bus
);
    localparam int EW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [EW-1:0]   mcand;
    logic [EW-1:0]   acc;
    logic [EW-1:0]   mplier;
    logic            q_m1;
    logic [CW-1:0]   count;
    logic [EW-1:0]   sum;
    logic [2*EW-1:0] shifted;
    logic            last;
    logic            accept;

    // Booth pair {q0, q(-1)}: 10 subtracts, 01 adds, 00/11 pass through.
    // Operands are one bit wider than WIDTH, so the accumulator never overflows.
    assign sum = (mplier[0] & ~q_m1) ? acc - mcand :
                 (~mplier[0] & q_m1) ? acc + mcand : acc;
    // Arithmetic right shift of the combined {acc, mplier} pair.
    assign shifted = {sum[EW-1], sum, mplier[EW-1:1]};
    assign last    = count == CW'(WIDTH);
    assign accept  = state == IDLE && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE ? (bus.in_valid  ? RUN  : IDLE) :
                     state == RUN  ? (last          ? DONE : RUN)  :
                     state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
    end

    always_comb begin
        bus.in_ready  = !rst && state == IDLE;
        bus.busy      = !rst && state != IDLE;
        bus.out_valid = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
            bus.p  <= '0;
        end else if (accept) begin
            mcand  <= {bus.signed_mode & bus.a[WIDTH-1], bus.a};
            mplier <= {bus.signed_mode & bus.b[WIDTH-1], bus.b};
            acc    <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
        end else if (state == RUN) begin
            acc    <= shifted[2*EW-1:EW];
            mplier <= shifted[EW-1:0];
            q_m1   <= mplier[0];
            count  <= count + 1'b1;
            if (last) bus.p <= shifted[2*WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_binary_mul_seq_booth.sv
// tb_binary_mul_seq_booth: scoreboard bench, directed WIDTH=9 vectors plus WIDTH=4 exhaustive sweep.
module tb_binary_mul_seq_booth;
    logic clk = 1'b0;
    logic rst9 = 1'b1;
    logic rst4 = 1'b1;
    logic done4 = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [17:0] q9[$];
    logic [7:0]  q4[$];

    always #5 clk = ~clk;

    binary_mul_seq_booth_if #(.WIDTH(9)) v9 ();
    binary_mul_seq_booth_if #(.WIDTH(4)) v4 ();

    binary_mul_seq_booth #(.WIDTH(9)) dut9 (.clk(clk), .rst(rst9), .bus(v9));
    binary_mul_seq_booth #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(v4));

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start9(input logic [8:0] a, input logic [8:0] b, input logic sm,
                          input logic push, input logic [17:0] exp);
        int k = 0;
        while (!v9.in_ready && k < 100) begin step(); k++; end
        chk("w9_ready_before_accept", 32'(v9.in_ready), 32'd1);
        v9.a = a;
        v9.b = b;
        v9.signed_mode = sm;
        v9.in_valid = 1'b1;
        if (push) q9.push_back(exp);
        step();
        v9.in_valid = 1'b0;
    endtask

    task automatic wait_out9(output int cyc);
        cyc = 0;
        while (!v9.out_valid && cyc < 60) begin step(); cyc++; end
        chk("w9_out_valid_seen", 32'(v9.out_valid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst9 && v9.out_valid && v9.out_ready) begin
            if (q9.size() == 0) begin
                n_total++;
                $display("FAIL w9_unexpected_output actual=%h required=none", v9.p);
            end else chk("w9_product", 32'(v9.p), 32'(q9.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst4 && v4.out_valid && v4.out_ready) begin
            if (q4.size() == 0) begin
                n_total++;
                $display("FAIL w4_unexpected_output actual=%h required=none", v4.p);
            end else chk("w4_product", 32'(v4.p), 32'(q4.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            v4.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int k;
        v4.in_valid = 1'b0;
        v4.a = '0;
        v4.b = '0;
        v4.signed_mode = 1'b0;
        v4.out_ready = 1'b0;
        repeat (3) step();
        rst4 = 1'b0;
        for (int sm = 0; sm < 2; sm++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    logic [3:0] a4;
                    logic [3:0] b4;
                    a4 = 4'(ai);
                    b4 = 4'(bi);
                    k = 0;
                    while (!v4.in_ready && k < 100) begin step(); k++; end
                    if (!v4.in_ready) begin
                        n_total++;
                        $display("FAIL w4_ready_timeout actual=0 required=1");
                    end
                    v4.a = a4;
                    v4.b = b4;
                    v4.signed_mode = 1'(sm);
                    v4.in_valid = 1'b1;
                    q4.push_back(sm != 0 ? {{4{a4[3]}}, a4} * {{4{b4[3]}}, b4}
                                         : {4'b0, a4} * {4'b0, b4});
                    step();
                    v4.in_valid = 1'b0;
                end
            end
        end
        k = 0;
        while (q4.size() != 0 && k < 200) begin step(); k++; end
        done4 = 1'b1;
    end

    initial begin
        int cyc;
        v9.a = 9'd3;
        v9.b = 9'd3;
        v9.signed_mode = 1'b0;
        v9.in_valid = 1'b1;
        v9.out_ready = 1'b1;
        repeat (3) step();
        chk("reset_in_ready", 32'(v9.in_ready), 32'd0);
        chk("reset_busy", 32'(v9.busy), 32'd0);
        chk("reset_out_valid", 32'(v9.out_valid), 32'd0);
        chk("reset_p", 32'(v9.p), 32'd0);
        rst9 = 1'b0;
        v9.in_valid = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(v9.in_ready), 32'd1);
        step();
        chk("reset_with_valid_not_accepted", 32'(v9.busy), 32'd0);

        start9(9'h100, 9'h100, 1'b1, 1'b1, 18'h10000);
        wait_out9(cyc);
        chk("w9_latency", 32'(cyc), 32'd10);
        step();
        chk("handshake_out_valid_low", 32'(v9.out_valid), 32'd0);
        chk("handshake_in_ready_high", 32'(v9.in_ready), 32'd1);

        start9(9'h1FF, 9'h1FF, 1'b0, 1'b1, 18'h3FC01);
        wait_out9(cyc);
        step();
        start9(9'h1FF, 9'h0FF, 1'b1, 1'b1, 18'h3FF01);
        wait_out9(cyc);
        step();

        v9.out_ready = 1'b0;
        start9(9'd100, 9'd3, 1'b0, 1'b1, 18'd300);
        wait_out9(cyc);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(v9.out_valid), 32'd1);
            chk("stall_p", 32'(v9.p), 32'd300);
            chk("stall_in_ready", 32'(v9.in_ready), 32'd0);
            step();
        end
        v9.out_ready = 1'b1;
        step();
        chk("release_out_valid", 32'(v9.out_valid), 32'd0);
        chk("release_in_ready", 32'(v9.in_ready), 32'd1);
        chk("release_p_held", 32'(v9.p), 32'd300);

        start9(9'd7, 9'd7, 1'b0, 1'b1, 18'd49);
        v9.a = 9'd3;
        v9.b = 9'd4;
        v9.in_valid = 1'b1;
        repeat (3) step();
        chk("run_busy", 32'(v9.busy), 32'd1);
        chk("run_in_ready", 32'(v9.in_ready), 32'd0);
        v9.in_valid = 1'b0;
        wait_out9(cyc);
        chk("ignored_input_latency", 32'(cyc), 32'd7);
        step();

        start9(9'd5, 9'd5, 1'b0, 1'b0, 18'd0);
        repeat (4) step();
        rst9 = 1'b1;
        step();
        chk("midrun_reset_out_valid", 32'(v9.out_valid), 32'd0);
        chk("midrun_reset_p", 32'(v9.p), 32'd0);
        chk("midrun_reset_busy", 32'(v9.busy), 32'd0);
        rst9 = 1'b0;
        #1;
        chk("midrun_reset_in_ready", 32'(v9.in_ready), 32'd1);
        start9(9'd5, 9'd6, 1'b0, 1'b1, 18'd30);
        wait_out9(cyc);
        chk("after_reset_latency", 32'(cyc), 32'd10);
        step();

        wait (done4);
        chk("w9_queue_drained", 32'(q9.size()), 32'd0);
        chk("w4_queue_drained", 32'(q4.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
